// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - hazard detection and forwarding control for the 5-stage pipeline
//
// Tracks the destination registers of the instructions in EX, MEM and WB and
// decides, for the instruction sitting in ID, whether the front end must stall,
// whether a taken branch flushes, and where EX should take its ALU operands.
//
// Ports:
//   clk_HU, rstn_HU        clock, asynchronous active-low reset
//   id_valid_HU            ID holds a real instruction
//   id_rs_HU, id_rt_HU     source register fields in ID
//   id_use_rs_HU/_rt_HU    ID instruction actually reads rs / rt
//   id_wr_HU, id_dst_HU    ID instruction writes id_dst_HU
//   id_load_HU             ID instruction is a load
//   mem_br_taken_HU        branch resolved taken in MEM
//   pc_en_HU, ifid_en_HU   front-end enables (low while stalled)
//   bubble_HU              insert a NOP into ID/EX
//   flush_HU               clear IF/ID, ID/EX and EX/MEM
//   fwd_a_HU, fwd_b_HU     operand sources for the instruction now in EX
//                          00 regfile, 01 EX/MEM, 10 MEM/WB, 11 WB hold reg
//   stall_cnt_HU           saturating count of stalled cycles
//   flush_cnt_HU           saturating count of taken-branch flushes

module pipe_hazard_unit #(
   parameter int REG_AW = 5,
   parameter int FWD_EN = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk_HU,
   input  logic              rstn_HU,
   input  logic              id_valid_HU,
   input  logic [REG_AW-1:0] id_rs_HU,
   input  logic [REG_AW-1:0] id_rt_HU,
   input  logic              id_use_rs_HU,
   input  logic              id_use_rt_HU,
   input  logic              id_wr_HU,
   input  logic [REG_AW-1:0] id_dst_HU,
   input  logic              id_load_HU,
   input  logic              mem_br_taken_HU,
   output logic              pc_en_HU,
   output logic              ifid_en_HU,
   output logic              bubble_HU,
   output logic              flush_HU,
   output logic [1:0]        fwd_a_HU,
   output logic [1:0]        fwd_b_HU,
   output logic [CNT_W-1:0]  stall_cnt_HU,
   output logic [CNT_W-1:0]  flush_cnt_HU
);

   localparam logic FWD = (FWD_EN != 0);

   // In-flight destination scoreboard. Only the EX slot needs the load flag:
   // a load is only a problem while it is still in EX.
   logic              ex_v, mem_v, wb_v;
   logic [REG_AW-1:0] ex_dst, mem_dst, wb_dst;
   logic              ex_ld;

   logic use_a, use_b;
   logic a_ex, a_mem, a_wb;
   logic b_ex, b_mem, b_wb;
   logic stall_cond, stall, flush;
   logic [1:0] fwd_a_nxt, fwd_b_nxt;

   // Newest producer wins so the consumer sees the most recent write.
   function automatic logic [1:0] fwd_sel(input logic m_ex, input logic m_mem, input logic m_wb);
      if (m_ex)
         return 2'b01;
      else if (m_mem)
         return 2'b10;
      else if (m_wb)
         return 2'b11;
      else
         return 2'b00;
   endfunction

   assign use_a = id_valid_HU & id_use_rs_HU;
   assign use_b = id_valid_HU & id_use_rt_HU;

   assign a_ex  = use_a & ex_v  & (ex_dst  == id_rs_HU);
   assign a_mem = use_a & mem_v & (mem_dst == id_rs_HU);
   assign a_wb  = use_a & wb_v  & (wb_dst  == id_rs_HU);
   assign b_ex  = use_b & ex_v  & (ex_dst  == id_rt_HU);
   assign b_mem = use_b & mem_v & (mem_dst == id_rt_HU);
   assign b_wb  = use_b & wb_v  & (wb_dst  == id_rt_HU);

   // With forwarding only a load in EX cannot be bypassed; without it any
   // in-flight producer blocks until it has been written back.
   assign stall_cond = FWD ? (ex_ld & (a_ex | b_ex))
                           : (a_ex | a_mem | a_wb | b_ex | b_mem | b_wb);

   // A taken branch kills the ID instruction anyway, so it never stalls.
   assign flush = mem_br_taken_HU;
   assign stall = stall_cond & ~flush;

   assign pc_en_HU   = ~stall;
   assign ifid_en_HU = ~stall;
   assign bubble_HU  = stall;
   assign flush_HU   = flush;

   // Selects are only meaningful when the ID instruction really moves into EX.
   assign fwd_a_nxt = (!FWD || stall || flush) ? 2'b00 : fwd_sel(a_ex, a_mem, a_wb);
   assign fwd_b_nxt = (!FWD || stall || flush) ? 2'b00 : fwd_sel(b_ex, b_mem, b_wb);

   always_ff @(posedge clk_HU or negedge rstn_HU) begin
      if (!rstn_HU) begin
         ex_v         <= 1'b0;
         mem_v        <= 1'b0;
         wb_v         <= 1'b0;
         ex_dst       <= '0;
         mem_dst      <= '0;
         wb_dst       <= '0;
         ex_ld        <= 1'b0;
         fwd_a_HU     <= 2'b00;
         fwd_b_HU     <= 2'b00;
         stall_cnt_HU <= '0;
         flush_cnt_HU <= '0;
      end else begin
         wb_v   <= mem_v;
         wb_dst <= mem_dst;
         if (flush) begin
            mem_v <= 1'b0;
            ex_v  <= 1'b0;
         end else begin
            mem_v   <= ex_v;
            mem_dst <= ex_dst;
            // $0 is hard-wired, so writes to it never create a dependency.
            ex_v    <= ~stall & id_valid_HU & id_wr_HU & (id_dst_HU != '0);
            ex_dst  <= id_dst_HU;
            ex_ld   <= id_load_HU;
         end

         fwd_a_HU <= fwd_a_nxt;
         fwd_b_HU <= fwd_b_nxt;

         if (stall && (stall_cnt_HU != '1))
            stall_cnt_HU <= stall_cnt_HU + 1'b1;
         if (flush && (flush_cnt_HU != '1))
            flush_cnt_HU <= flush_cnt_HU + 1'b1;
      end
   end

endmodule
